icache: RTL and testbench
=========================

# icache

Direct-mapped instruction cache answering the fetcher's per-PC lookup and capturing instruction words returned by the memory controller on fetcher-initiated misses. Lookup is combinational on the fetcher's registered PC: a hit is presented in the same cycle the request is visible. Fill uses a one-entry pending-miss register, so a memory return arriving after a pipeline flush still lands at the correct address. The block sits between the fetcher and the memory controller's instruction-return path.

## Interface
- ICACHE_INDEX_BITS, 6, log2 of entry count (64 entries, one instruction word per entry)
- clk  in  1  clock, all state updates on posedge
- rst  in  1  synchronous, active-high reset, sampled only when rdy=1
- rdy  in  1  global enable; when 0, no state changes
- fet_icache_enable  in  1  lookup request valid
- fet_pc  in  XLEN  lookup address, 2-byte aligned (C extension)
- fet_mem_enable  in  1  fetcher starts a memory fetch for fet_pc (miss)
- mem_inst_ready  in  1  memory controller instruction return valid
- mem_inst  in  XLEN  returned instruction word (32 bits starting at the miss address)
- icache_ready  out  1  hit: fet_icache_enable && valid[idx] && tag[idx]==tag(fet_pc)
- icache_inst  out  XLEN  data[idx], meaningful only when icache_ready=1

## Operation
- Address split: idx = fet_pc[ICACHE_INDEX_BITS:1]; tag = fet_pc[XLEN-1:ICACHE_INDEX_BITS+1]; bit 0 ignored.
- Arrays: valid bit vector, tag array, data array (XLEN per entry).
- States: IDLE, PENDING. Register miss_addr (XLEN).
- IDLE: if fet_mem_enable, set miss_addr <= fet_pc and go to PENDING.
- PENDING: on mem_inst_ready, write valid/tag/data at idx(miss_addr) with mem_inst and return to IDLE. If fet_mem_enable and mem_inst_ready occur in the same cycle, complete the fill and latch the new miss_addr, staying in PENDING.
- mem_inst_ready in IDLE: ignored, no write.
- Flush is not an input. A return after a flush fills using miss_addr, which is always correct for that data.
- Fill overwrites a conflicting entry unconditionally (no replacement choice).
- No store coherence: self-modifying code is unsupported, and entries are never invalidated except by rst.
- Reset: all valid bits 0, state IDLE, miss_addr 0. Outputs after reset: icache_ready=0; icache_inst=data[idx], don't-care.
- rst during PENDING: the pending fill is dropped, and a later mem_inst_ready is ignored.

## Timing
- Hit latency 0 cycles: icache_ready/icache_inst are combinational from fet_pc and the arrays.
- Fill is written at the posedge where mem_inst_ready=1. A lookup of the same address is a hit from the next cycle.
- A same-cycle lookup of the entry being filled sees the old contents (miss). The fetcher uses mem_inst directly in that cycle.
- rdy=0 freezes all state. Combinational outputs still follow the inputs.

## Configuration
- ICACHE_STAT_EN defined:
  - Adds outputs icache_hit_cnt and icache_miss_cnt, 32 bits each, reset to 0.
  - hit_cnt increments on each rdy && !rst cycle with icache_ready=1.
  - miss_cnt increments on each rdy && !rst cycle with fet_mem_enable=1.
  - Both counters wrap at 2^32.
- ICACHE_STAT_EN undefined: those ports and counters do not exist. Behaviour is otherwise identical.

## Structure
- XLEN and ICACHE_INDEX_BITS default in global_params.v. The tag width is derived there as XLEN-ICACHE_INDEX_BITS-1.
- One sub-module, icache_array: valid/tag/data storage with one combinational read port, one synchronous write port and synchronous clear. The top level holds the IDLE/PENDING control, miss_addr and the counters.

## Test plan
- After reset, fet_icache_enable=1, fet_pc=0x0 -> icache_ready=0. fet_mem_enable=1, then 3 cycles later mem_inst_ready=1 with mem_inst=0x00500093 -> next cycle lookup of 0x0 gives icache_ready=1, icache_inst=0x00500093.
- Fill 0x0 and 0x80, where both map to idx 0 with ICACHE_INDEX_BITS=6 -> lookup 0x0 misses, 0x80 hits. Lookup 0x2 (idx 1) misses.
- Miss on 0x100, then fet_pc changes to 0x200 (flush) before the return, then mem_inst_ready with 0x12345678 -> 0x100 hits with 0x12345678 and 0x200 misses.
- mem_inst_ready=1 in IDLE with mem_inst=0xDEADBEEF -> no entry changes. Every lookup still misses.
- Fill 0x40, then assert rst for 1 cycle -> lookup 0x40 misses. rst during PENDING followed by mem_inst_ready -> no fill.
- With ICACHE_STAT_EN: 2 hits and 1 miss -> hit_cnt=2, miss_cnt=1. Hold rdy=0 for 5 cycles -> counters unchanged.

Source files
------------

// File: rtl/icache_pkg.sv
// Shared parameters, FSM state type and PC field helpers for the direct-mapped instruction cache.
package icache_pkg;

    localparam int XLEN              = 32;
    localparam int ICACHE_INDEX_BITS = 6;
    localparam int ICACHE_TAG_BITS   = XLEN - ICACHE_INDEX_BITS - 1;
    localparam int ICACHE_ENTRIES    = 1 << ICACHE_INDEX_BITS;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PENDING = 1'b1
    } icache_state_t;

    // Bit 0 is never part of the index or tag: fetch addresses are halfword aligned.
    function automatic logic [ICACHE_INDEX_BITS-1:0] pc_index(input logic [XLEN-1:0] pc);
        return pc[ICACHE_INDEX_BITS:1];
    endfunction

    function automatic logic [ICACHE_TAG_BITS-1:0] pc_tag(input logic [XLEN-1:0] pc);
        return pc[XLEN-1:ICACHE_INDEX_BITS+1];
    endfunction

endpackage

// File: rtl/icache_if.sv
// Fetcher / memory-return bundle seen by the icache; the cache is the slave side.
interface icache_if;
    import icache_pkg::*;

    logic            fet_icache_enable;
    logic [XLEN-1:0] fet_pc;
    logic            fet_mem_enable;
    logic            mem_inst_ready;
    logic [XLEN-1:0] mem_inst;
    logic            icache_ready;
    logic [XLEN-1:0] icache_inst;

    modport master (
        output fet_icache_enable, fet_pc, fet_mem_enable, mem_inst_ready, mem_inst,
        input  icache_ready, icache_inst
    );

    modport slave (
        input  fet_icache_enable, fet_pc, fet_mem_enable, mem_inst_ready, mem_inst,
        output icache_ready, icache_inst
    );

endinterface

// File: rtl/icache_array.sv
// Valid/tag/data storage: one combinational read port, one synchronous write port,
// synchronous clear of the valid bits.
module icache_array
    import icache_pkg::*;
(
    input  logic                         clk,
    input  logic                         i_clr,
    input  logic                         i_we,
    input  logic [ICACHE_INDEX_BITS-1:0] i_wr_idx,
    input  logic [ICACHE_TAG_BITS-1:0]   i_wr_tag,
    input  logic [XLEN-1:0]              i_wr_data,
    input  logic [ICACHE_INDEX_BITS-1:0] i_rd_idx,
    output logic                         o_rd_valid,
    output logic [ICACHE_TAG_BITS-1:0]   o_rd_tag,
    output logic [XLEN-1:0]              o_rd_data
);

    logic [ICACHE_ENTRIES-1:0]  r_valid;
    logic [ICACHE_TAG_BITS-1:0] r_tag  [ICACHE_ENTRIES];
    logic [XLEN-1:0]            r_data [ICACHE_ENTRIES];
    logic [ICACHE_ENTRIES-1:0]  w_wr_sel;

    generate
        for (genvar gi = 0; gi < ICACHE_ENTRIES; gi++) begin : g_wr_sel
            assign w_wr_sel[gi] = i_we && (i_wr_idx == ICACHE_INDEX_BITS'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (i_clr) begin
            r_valid <= '0;
        end else begin
            r_valid <= r_valid | w_wr_sel;
        end
    end

    // Tag/data carry no reset; an entry is only trusted once its valid bit is set.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_tag[i_wr_idx]  <= i_wr_tag;
            r_data[i_wr_idx] <= i_wr_data;
        end
    end

    assign o_rd_valid = r_valid[i_rd_idx];
    assign o_rd_tag   = r_tag[i_rd_idx];
    assign o_rd_data  = r_data[i_rd_idx];

endmodule

// File: rtl/icache.sv
// Direct-mapped instruction cache: zero-latency lookup plus a one-entry pending-miss fill tracker.
// Optional hit/miss counters are built when ICACHE_STAT_EN is defined.
module icache
    import icache_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    icache_if.slave     bus
`ifdef ICACHE_STAT_EN
    ,
    output logic [31:0] icache_hit_cnt,
    output logic [31:0] icache_miss_cnt
`endif
);

    icache_state_t   r_state;
    logic [XLEN-1:0] r_miss_addr;

    logic                       w_clr;
    logic                       w_fill;
    logic                       w_rd_valid;
    logic [ICACHE_TAG_BITS-1:0] w_rd_tag;
    logic [XLEN-1:0]            w_rd_data;
    logic                       w_hit;

    // Reset only acts while the pipeline is enabled; rdy=0 freezes everything, rst included.
    assign w_clr  = rdy && rst;
    assign w_fill = rdy && !rst && (r_state == ST_PENDING) && bus.mem_inst_ready;

    icache_array u_array (
        .clk        (clk),
        .i_clr      (w_clr),
        .i_we       (w_fill),
        .i_wr_idx   (pc_index(r_miss_addr)),
        .i_wr_tag   (pc_tag(r_miss_addr)),
        .i_wr_data  (bus.mem_inst),
        .i_rd_idx   (pc_index(bus.fet_pc)),
        .o_rd_valid (w_rd_valid),
        .o_rd_tag   (w_rd_tag),
        .o_rd_data  (w_rd_data)
    );

    assign w_hit            = bus.fet_icache_enable && w_rd_valid && (w_rd_tag == pc_tag(bus.fet_pc));
    assign bus.icache_ready = w_hit;
    assign bus.icache_inst  = w_rd_data;

    // A new miss while one is outstanding is only accepted in the cycle the old one returns,
    // so the data in flight always lands at the address it was fetched for.
    always_ff @(posedge clk) begin
        if (rdy) begin
            if (rst) begin
                r_state     <= ST_IDLE;
                r_miss_addr <= '0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (bus.fet_mem_enable) begin
                            r_miss_addr <= bus.fet_pc;
                            r_state     <= ST_PENDING;
                        end
                    end
                    ST_PENDING: begin
                        if (bus.mem_inst_ready) begin
                            if (bus.fet_mem_enable) begin
                                r_miss_addr <= bus.fet_pc;
                                r_state     <= ST_PENDING;
                            end else begin
                                r_state     <= ST_IDLE;
                            end
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

`ifdef ICACHE_STAT_EN
    logic [31:0] r_hit_cnt;
    logic [31:0] r_miss_cnt;

    always_ff @(posedge clk) begin
        if (rdy) begin
            if (rst) begin
                r_hit_cnt  <= '0;
                r_miss_cnt <= '0;
            end else begin
                if (w_hit) begin
                    r_hit_cnt <= r_hit_cnt + 32'd1;
                end
                if (bus.fet_mem_enable) begin
                    r_miss_cnt <= r_miss_cnt + 32'd1;
                end
            end
        end
    end

    assign icache_hit_cnt  = r_hit_cnt;
    assign icache_miss_cnt = r_miss_cnt;
`endif

endmodule

// File: tb/tb_icache.sv
// Directed self-checking bench for icache; stat-counter checks are built when ICACHE_STAT_EN is defined.
module tb_icache;
    import icache_pkg::*;

    logic clk;
    logic rst;
    logic rdy;

    icache_if bus ();

`ifdef ICACHE_STAT_EN
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;
`endif

    icache dut (
        .clk             (clk),
        .rst             (rst),
        .rdy             (rdy),
        .bus             (bus.slave)
`ifdef ICACHE_STAT_EN
        ,
        .icache_hit_cnt  (hit_cnt),
        .icache_miss_cnt (miss_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s = 0x%08h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic lookup(input string tag, input logic [31:0] addr,
                          input logic exp_hit, input logic [31:0] exp_data);
        bus.fet_icache_enable = 1'b1;
        bus.fet_pc            = addr;
        #1;
        chk({tag, "_ready"}, {31'd0, bus.icache_ready}, {31'd0, exp_hit});
        if (exp_hit) chk({tag, "_inst"}, bus.icache_inst, exp_data);
    endtask

    // Miss request, two idle cycles, return on the third; the return cycle itself must still miss.
    task automatic fill(input string tag, input logic [31:0] addr, input logic [31:0] data);
        bus.fet_pc         = addr;
        bus.fet_mem_enable = 1'b1;
        tick();
        bus.fet_mem_enable = 1'b0;
        tick();
        tick();
        bus.mem_inst_ready = 1'b1;
        bus.mem_inst       = data;
        lookup({tag, "_same_cycle"}, addr, 1'b0, 32'h0);
        tick();
        bus.mem_inst_ready    = 1'b0;
        bus.fet_icache_enable = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        rdy = 1'b1;
        bus.fet_icache_enable = 1'b0;
        bus.fet_pc            = '0;
        bus.fet_mem_enable    = 1'b0;
        bus.mem_inst_ready    = 1'b0;
        bus.mem_inst          = '0;
        tick();
        tick();
        rst = 1'b0;

        // basic fill and hit
        lookup("reset_miss_0x0", 32'h0, 1'b0, 32'h0);
        fill("fill_0x0", 32'h0, 32'h0050_0093);
        lookup("hit_0x0", 32'h0, 1'b1, 32'h0050_0093);

        // conflicting index 0
        fill("fill_0x80", 32'h80, 32'h1111_1111);
        lookup("evicted_0x0", 32'h0, 1'b0, 32'h0);
        lookup("hit_0x80", 32'h80, 1'b1, 32'h1111_1111);
        lookup("miss_0x2", 32'h2, 1'b0, 32'h0);

        // PC moves away (flush) before the return
        bus.fet_pc         = 32'h100;
        bus.fet_mem_enable = 1'b1;
        tick();
        bus.fet_mem_enable = 1'b0;
        bus.fet_pc         = 32'h200;
        tick();
        bus.mem_inst_ready = 1'b1;
        bus.mem_inst       = 32'h1234_5678;
        tick();
        bus.mem_inst_ready = 1'b0;
        lookup("flush_hit_0x100", 32'h100, 1'b1, 32'h1234_5678);
        lookup("flush_miss_0x200", 32'h200, 1'b0, 32'h0);

        // return while idle is ignored
        bus.fet_icache_enable = 1'b0;
        bus.mem_inst_ready    = 1'b1;
        bus.mem_inst          = 32'hDEAD_BEEF;
        tick();
        bus.mem_inst_ready    = 1'b0;
        lookup("idle_ret_0x100", 32'h100, 1'b1, 32'h1234_5678);
        lookup("idle_ret_miss_0x0", 32'h0, 1'b0, 32'h0);
        lookup("idle_ret_miss_0x200", 32'h200, 1'b0, 32'h0);

        // reset invalidates
        fill("fill_0x40", 32'h40, 32'h4040_4040);
        lookup("hit_0x40", 32'h40, 1'b1, 32'h4040_4040);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        lookup("rst_miss_0x40", 32'h40, 1'b0, 32'h0);
        lookup("rst_miss_0x100", 32'h100, 1'b0, 32'h0);

        // reset while pending drops the fill
        bus.fet_pc         = 32'h40;
        bus.fet_mem_enable = 1'b1;
        tick();
        bus.fet_mem_enable = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.mem_inst_ready = 1'b1;
        bus.mem_inst       = 32'h5555_AAAA;
        tick();
        bus.mem_inst_ready = 1'b0;
        lookup("rst_pend_miss_0x40", 32'h40, 1'b0, 32'h0);

        // rdy=0 blocks miss capture
        rdy = 1'b0;
        bus.fet_pc         = 32'h8;
        bus.fet_mem_enable = 1'b1;
        tick();
        rdy = 1'b1;
        bus.fet_mem_enable = 1'b0;
        bus.mem_inst_ready = 1'b1;
        bus.mem_inst       = 32'hAAAA_0008;
        tick();
        bus.mem_inst_ready = 1'b0;
        lookup("frozen_req_miss_0x8", 32'h8, 1'b0, 32'h0);

        // rdy=0 blocks the fill, which then lands once rdy returns
        bus.fet_pc         = 32'hC;
        bus.fet_mem_enable = 1'b1;
        tick();
        bus.fet_mem_enable = 1'b0;
        rdy = 1'b0;
        bus.mem_inst_ready = 1'b1;
        bus.mem_inst       = 32'hCCCC_000C;
        tick();
        lookup("frozen_fill_miss_0xC", 32'hC, 1'b0, 32'h0);
        rdy = 1'b1;
        tick();
        bus.mem_inst_ready = 1'b0;
        lookup("thawed_fill_hit_0xC", 32'hC, 1'b1, 32'hCCCC_000C);
        rdy = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        rdy = 1'b1;
        lookup("frozen_rst_hit_0xC", 32'hC, 1'b1, 32'hCCCC_000C);

        // return and new miss in the same cycle
        bus.fet_pc         = 32'h10;
        bus.fet_mem_enable = 1'b1;
        tick();
        bus.fet_pc         = 32'h14;
        bus.mem_inst_ready = 1'b1;
        bus.mem_inst       = 32'h1010_1010;
        tick();
        bus.fet_mem_enable = 1'b0;
        bus.mem_inst       = 32'h1414_1414;
        tick();
        bus.mem_inst_ready = 1'b0;
        lookup("b2b_hit_0x10", 32'h10, 1'b1, 32'h1010_1010);
        lookup("b2b_hit_0x14", 32'h14, 1'b1, 32'h1414_1414);

`ifdef ICACHE_STAT_EN
        bus.fet_icache_enable = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("stat_rst_hit", hit_cnt, 32'd0);
        chk("stat_rst_miss", miss_cnt, 32'd0);
        fill("stat_fill_0x20", 32'h20, 32'h2020_2020);
        lookup("stat_hit_0x20", 32'h20, 1'b1, 32'h2020_2020);
        tick();
        tick();
        bus.fet_icache_enable = 1'b0;
        chk("stat_hit_cnt", hit_cnt, 32'd2);
        chk("stat_miss_cnt", miss_cnt, 32'd1);
        rdy = 1'b0;
        bus.fet_icache_enable = 1'b1;
        bus.fet_mem_enable    = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        rdy = 1'b1;
        bus.fet_icache_enable = 1'b0;
        bus.fet_mem_enable    = 1'b0;
        chk("stat_frozen_hit", hit_cnt, 32'd2);
        chk("stat_frozen_miss", miss_cnt, 32'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
